flood_game_ctrl: RTL and testbench
==================================

Name: flood_game_ctrl

Overview:
- Top-level game sequencer for Flood-It.
- Latches player settings and captures a seed. Drives the board generator through its INITIALIZE_BOARD/BOARD_READY handshake.
- Then arbitrates player moves into the flood-fill engine, counts moves and declares win/loss.
- Sits between the input debouncers and the generate_board / flood-fill datapath blocks.

Parameters:
- MIN_SIZE, 2, smallest legal board edge; smaller size_sel is clamped up to this.
- MAX_SIZE, 26, largest legal board edge; larger size_sel is clamped down to this.
- MIN_COLORS, 3, smallest legal colour count (clamp).
- MAX_COLORS, 8, largest legal colour count (clamp).

Ports:
- CLOCK  in  1  system clock, all logic on posedge.
- RESET_N  in  1  synchronous active-low reset.
- START_BTN  in  1  one-cycle debounced pulse; new game.
- size_sel  in  5  requested board edge.
- color_sel  in  4  requested colour count.
- move_valid  in  1  one-cycle pulse, player move present.
- move_color  in  3  colour of the player move.
- corner_color  in  3  current colour of cell [0][0] from board RAM.
- flood_done  in  1  one-cycle pulse from flood engine, fill finished.
- board_won  in  1  level from flood engine, board is single-coloured.
- BOARD_READY  in  1  from generator.
- seed  out  16  seed to generator.
- INITIALIZE_BOARD  out  1  generator request.
- final_SIZE  out  5  latched, clamped edge.
- final_COLOR_NUM  out  4  latched, clamped colour count.
- flood_start  out  1  one-cycle pulse to flood engine.
- flood_color  out  3  colour for the fill; valid while flood_start=1.
- move_count  out  8  moves taken this game.
- move_limit  out  8  allowed moves this game.
- PLAYING  out  1  high in PLAY/FLOOD/CHECK.
- GAME_WON  out  1  high in WON.
- GAME_LOST  out  1  high in LOST.

Behaviour:
- **Reset (RESET_N=0 at posedge, any state)**
  - State goes to IDLE.
  - All outputs 0, except final_SIZE=MIN_SIZE and final_COLOR_NUM=MIN_COLORS.
  - Free-running seed counter resets to 16'h0001.
- **Seed counter:** 16-bit free-running counter, increments every cycle in all states, wraps 16'hFFFF->16'h0000.
- **States:** IDLE, CONFIG, GEN, DRAIN, PLAY, FLOOD, CHECK, WON, LOST.
- **IDLE:** START_BTN -> CONFIG.
- **CONFIG (1 cycle)**
  - final_SIZE <= clamp(size_sel, MIN_SIZE, MAX_SIZE).
  - final_COLOR_NUM <= clamp(color_sel, MIN_COLORS, MAX_COLORS).
  - seed <= counter value.
  - move_count <= 0.
  - move_limit <= size + (size>>1) + colors, computed from the clamped values in 8 bits (no overflow within ranges; 14/6 -> 27).
  - Next state GEN.
- **GEN**
  - INITIALIZE_BOARD=1, held until BOARD_READY=1 is sampled.
  - That cycle: INITIALIZE_BOARD<=0, -> DRAIN.
  - seed, final_SIZE and final_COLOR_NUM are stable throughout GEN.
- **DRAIN:** wait for BOARD_READY=0 (generator clears it once init drops), then -> PLAY. Guarantees the generator is rearmed.
- **PLAY**
  - A move is accepted only if: move_valid=1, move_color < final_COLOR_NUM, and move_color != corner_color.
  - Rejected moves are dropped silently; count and state are unchanged.
  - Accept: flood_start=1 for exactly one cycle (the next cycle), flood_color=move_color, move_count<=move_count+1 (saturate at 255), -> FLOOD.
- **FLOOD**
  - Wait for flood_done.
  - move_valid is ignored here (no queuing).
  - On flood_done -> CHECK.
- **CHECK (1 cycle, board_won sampled here)**
  - board_won=1 -> WON. Win has priority over limit: winning on the last allowed move is a win.
  - Else move_count >= move_limit -> LOST.
  - Else -> PLAY.
- **WON / LOST:** hold outputs. START_BTN -> CONFIG.
- **START_BTN in other states**
  - PLAY/FLOOD/CHECK: START_BTN aborts to CONFIG (new game). flood_start is never issued in the abort cycle.
  - GEN/DRAIN: START_BTN ignored, so generator handshake integrity is kept.
- **Simultaneous events**
  - START_BTN and move_valid in the same PLAY cycle: START wins, move dropped.
  - flood_done and START_BTN in FLOOD: START wins.
- **Output mapping:** PLAYING/GAME_WON/GAME_LOST are registered decodes of the state; exactly one or none is high.

Test Plan:
- Reset then START_BTN with size_sel=14, color_sel=6 -> CONFIG then GEN. Expect final_SIZE=14, final_COLOR_NUM=6, move_limit=27, INITIALIZE_BOARD high until model BOARD_READY, then low; PLAY only after BOARD_READY falls.
- size_sel=0, color_sel=15 -> final_SIZE=2, final_COLOR_NUM=8, move_limit=2+1+8=11.
- In PLAY with corner_color=2, colors=4: moves of colour 2, 5 and 7 -> no flood_start, move_count stays 0. Colour 3 -> one flood_start pulse, flood_color=3, move_count=1.
- Limit case: move_limit=11, drive 11 accepted moves with board_won=0 -> LOST after the 11th CHECK. Repeat with board_won=1 on the 11th -> WON.
- move_valid pulses during FLOOD -> ignored, move_count unchanged. START_BTN during FLOOD -> CONFIG, move_count=0, new seed differs from the previous one.
- RESET_N low for one cycle mid-GEN -> next cycle IDLE, INITIALIZE_BOARD=0, all status outputs 0. START_BTN during GEN (no reset) -> ignored, handshake completes normally.

Source files
------------

// File: rtl/flood_game_ctrl.sv
// Flood-It game sequencer: latches settings and seed, handshakes with the board
// generator, arbitrates player moves into the flood engine and declares win/loss.
module flood_game_ctrl #(
  parameter int unsigned MIN_SIZE   = 2,
  parameter int unsigned MAX_SIZE   = 26,
  parameter int unsigned MIN_COLORS = 3,
  parameter int unsigned MAX_COLORS = 8
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START_BTN,
  input  logic [4:0]  size_sel,
  input  logic [3:0]  color_sel,
  input  logic        move_valid,
  input  logic [2:0]  move_color,
  input  logic [2:0]  corner_color,
  input  logic        flood_done,
  input  logic        board_won,
  input  logic        BOARD_READY,
  output logic [15:0] seed,
  output logic        INITIALIZE_BOARD,
  output logic [4:0]  final_SIZE,
  output logic [3:0]  final_COLOR_NUM,
  output logic        flood_start,
  output logic [2:0]  flood_color,
  output logic [7:0]  move_count,
  output logic [7:0]  move_limit,
  output logic        PLAYING,
  output logic        GAME_WON,
  output logic        GAME_LOST
);

  localparam int unsigned SEED_W  = 16;
  localparam int unsigned SIZE_W  = 5;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [3:0] {
    IDLE, CONFIG, GEN, DRAIN, PLAY, FLOOD, CHECK, WON, LOST
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SEED_W-1:0]   seed_cnt;
  logic [SIZE_W-1:0]   size_clamp;
  logic [COLOR_W-1:0]  color_clamp;
  logic [CNT_W-1:0]    limit_calc;
  logic                move_ok;
  logic                accept;
  logic                playing_next;

  // Clamp requested settings into the legal board range
  always_comb begin
    size_clamp = size_sel;
    if (size_sel < SIZE_W'(MIN_SIZE)) begin
      size_clamp = SIZE_W'(MIN_SIZE);
    end else if (size_sel > SIZE_W'(MAX_SIZE)) begin
      size_clamp = SIZE_W'(MAX_SIZE);
    end
    color_clamp = color_sel;
    if (color_sel < COLOR_W'(MIN_COLORS)) begin
      color_clamp = COLOR_W'(MIN_COLORS);
    end else if (color_sel > COLOR_W'(MAX_COLORS)) begin
      color_clamp = COLOR_W'(MAX_COLORS);
    end
  end

  assign limit_calc = CNT_W'(size_clamp) + CNT_W'(size_clamp >> 1) + CNT_W'(color_clamp);

  assign move_ok = move_valid && ({1'b0, move_color} < final_COLOR_NUM)
                   && (move_color != corner_color);

  // Next-state logic; START_BTN outranks any concurrent move or flood completion
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE:   if (START_BTN) state_next = CONFIG;
      CONFIG: state_next = GEN;
      GEN:    if (BOARD_READY) state_next = DRAIN;
      DRAIN:  if (!BOARD_READY) state_next = PLAY;
      PLAY: begin
        if (START_BTN) begin
          state_next = CONFIG;
        end else if (move_ok) begin
          accept     = 1'b1;
          state_next = FLOOD;
        end
      end
      FLOOD: begin
        if (START_BTN) state_next = CONFIG;
        else if (flood_done) state_next = CHECK;
      end
      CHECK: begin
        if (START_BTN) state_next = CONFIG;
        else if (board_won) state_next = WON;
        else if (move_count >= move_limit) state_next = LOST;
        else state_next = PLAY;
      end
      WON, LOST: if (START_BTN) state_next = CONFIG;
      default: state_next = IDLE;
    endcase
  end

  assign playing_next = (state_next == PLAY) || (state_next == FLOOD) || (state_next == CHECK);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  // Registered outputs and game datapath
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      seed_cnt         <= SEED_W'(1);
      seed             <= '0;
      INITIALIZE_BOARD <= 1'b0;
      final_SIZE       <= SIZE_W'(MIN_SIZE);
      final_COLOR_NUM  <= COLOR_W'(MIN_COLORS);
      flood_start      <= 1'b0;
      flood_color      <= '0;
      move_count       <= '0;
      move_limit       <= '0;
      PLAYING          <= 1'b0;
      GAME_WON         <= 1'b0;
      GAME_LOST        <= 1'b0;
    end else begin
      seed_cnt         <= seed_cnt + SEED_W'(1);
      INITIALIZE_BOARD <= (state_next == GEN);
      flood_start      <= accept;
      PLAYING          <= playing_next;
      GAME_WON         <= (state_next == WON);
      GAME_LOST        <= (state_next == LOST);
      if (state == CONFIG) begin
        final_SIZE      <= size_clamp;
        final_COLOR_NUM <= color_clamp;
        seed            <= seed_cnt;
        move_count      <= '0;
        move_limit      <= limit_calc;
      end
      if (accept) begin
        flood_color <= move_color;
        if (move_count != {CNT_W{1'b1}}) move_count <= move_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_flood_game_ctrl.sv
// Directed bench for flood_game_ctrl: settings clamp, generator handshake,
// move filtering, limit/win resolution, aborts and mid-handshake reset.
module tb_flood_game_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START_BTN = 1'b0;
  logic [4:0]  size_sel = '0;
  logic [3:0]  color_sel = '0;
  logic        move_valid = 1'b0;
  logic [2:0]  move_color = '0;
  logic [2:0]  corner_color = '0;
  logic        flood_done = 1'b0;
  logic        board_won = 1'b0;
  logic        BOARD_READY = 1'b0;
  logic [15:0] seed;
  logic        INITIALIZE_BOARD;
  logic [4:0]  final_SIZE;
  logic [3:0]  final_COLOR_NUM;
  logic        flood_start;
  logic [2:0]  flood_color;
  logic [7:0]  move_count;
  logic [7:0]  move_limit;
  logic        PLAYING;
  logic        GAME_WON;
  logic        GAME_LOST;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] cnt_model;
  logic [15:0] prev_seed = '0;

  flood_game_ctrl dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START_BTN(START_BTN),
    .size_sel(size_sel), .color_sel(color_sel),
    .move_valid(move_valid), .move_color(move_color), .corner_color(corner_color),
    .flood_done(flood_done), .board_won(board_won), .BOARD_READY(BOARD_READY),
    .seed(seed), .INITIALIZE_BOARD(INITIALIZE_BOARD),
    .final_SIZE(final_SIZE), .final_COLOR_NUM(final_COLOR_NUM),
    .flood_start(flood_start), .flood_color(flood_color),
    .move_count(move_count), .move_limit(move_limit),
    .PLAYING(PLAYING), .GAME_WON(GAME_WON), .GAME_LOST(GAME_LOST)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference free-running seed counter
  always @(posedge CLOCK) begin
    if (!RESET_N) cnt_model <= 16'h0001;
    else          cnt_model <= cnt_model + 16'h0001;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // status: 0 playing, 1 won, 2 lost, 3 none
  task automatic check_status(input string tag, input int st);
    check({tag, "_playing"}, 32'(PLAYING),   32'(st == 0));
    check({tag, "_won"},     32'(GAME_WON),  32'(st == 1));
    check({tag, "_lost"},    32'(GAME_LOST), 32'(st == 2));
  endtask

  // START a game from any abortable state; any move_valid/flood_done already
  // driven by the caller coincides with the START cycle
  task automatic new_game(input int ssel, input int csel, input int esize,
                          input int ecol, input int elim);
    size_sel  = 5'(ssel);
    color_sel = 4'(csel);
    START_BTN = 1'b1;
    tick();
    START_BTN  = 1'b0;
    move_valid = 1'b0;
    flood_done = 1'b0;
    check("cfg_no_flood", 32'(flood_start), 0);
    check_status("cfg", 3);
    tick();
    check("final_size",  32'(final_SIZE), 32'(esize));
    check("final_color", 32'(final_COLOR_NUM), 32'(ecol));
    check("move_limit",  32'(move_limit), 32'(elim));
    check("count_clear", 32'(move_count), 0);
    check("gen_init",    32'(INITIALIZE_BOARD), 1);
    check("seed_capture", 32'(seed), 32'(cnt_model - 16'h0001));
    check("seed_new",    32'(seed != prev_seed), 1);
    prev_seed = seed;
  endtask

  task automatic gen_handshake(input bit poke_start);
    int n = 0;
    while (!INITIALIZE_BOARD && n < 20) begin
      tick();
      n++;
    end
    check("init_seen", 32'(INITIALIZE_BOARD), 1);
    tick();
    check("init_hold", 32'(INITIALIZE_BOARD), 1);
    if (poke_start) begin
      START_BTN = 1'b1;
      tick();
      START_BTN = 1'b0;
      check("gen_start_ignored", 32'(INITIALIZE_BOARD), 1);
      check("gen_seed_stable", 32'(seed), 32'(prev_seed));
    end
    BOARD_READY = 1'b1;
    tick();
    check("init_drop", 32'(INITIALIZE_BOARD), 0);
    check("drain_not_play", 32'(PLAYING), 0);
    tick();
    check("drain_hold", 32'(PLAYING), 0);
    BOARD_READY = 1'b0;
    tick();
    check_status("enter_play", 0);
  endtask

  task automatic reject_move(input int c, input int ecount);
    move_valid = 1'b1;
    move_color = 3'(c);
    tick();
    move_valid = 1'b0;
    check("rej_no_flood", 32'(flood_start), 0);
    check("rej_count", 32'(move_count), 32'(ecount));
    check("rej_playing", 32'(PLAYING), 1);
    tick();
    check("rej_no_flood2", 32'(flood_start), 0);
  endtask

  task automatic do_move(input int c, input bit won, input int ecount, input int est);
    move_valid = 1'b1;
    move_color = 3'(c);
    tick();
    move_valid = 1'b0;
    check("flood_pulse", 32'(flood_start), 1);
    check("flood_color", 32'(flood_color), 32'(c));
    check("move_count", 32'(move_count), 32'(ecount));
    tick();
    check("flood_one_cycle", 32'(flood_start), 0);
    flood_done = 1'b1;
    board_won  = won;
    tick();
    flood_done = 1'b0;
    tick();
    board_won = 1'b0;
    check_status("after_check", est);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_seed", 32'(seed), 0);
    check("rst_init", 32'(INITIALIZE_BOARD), 0);
    check("rst_size", 32'(final_SIZE), 2);
    check("rst_color", 32'(final_COLOR_NUM), 3);
    check("rst_flood", 32'(flood_start), 0);
    check("rst_count", 32'(move_count), 0);
    check("rst_limit", 32'(move_limit), 0);
    check_status("rst", 3);
    RESET_N = 1'b1;
    repeat (2) tick();
    check("idle_init", 32'(INITIALIZE_BOARD), 0);

    // Game A: 14/6, moves during FLOOD ignored, START aborts FLOOD
    new_game(14, 6, 14, 6, 27);
    gen_handshake(1'b0);
    corner_color = 3'd0;
    move_valid = 1'b1;
    move_color = 3'd1;
    tick();
    move_valid = 1'b0;
    check("a_flood_pulse", 32'(flood_start), 1);
    check("a_count", 32'(move_count), 1);
    for (int i = 0; i < 2; i++) begin
      move_valid = 1'b1;
      move_color = 3'd3;
      tick();
      move_valid = 1'b0;
      check("a_flood_ignore", 32'(flood_start), 0);
      check("a_flood_count", 32'(move_count), 1);
      check("a_flood_color", 32'(flood_color), 1);
    end
    new_game(0, 15, 2, 8, 11);

    // Game B: 11 moves without a win ends in LOST
    gen_handshake(1'b0);
    for (int i = 1; i <= 11; i++) begin
      do_move((i % 7) + 1, 1'b0, i, (i == 11) ? 2 : 0);
    end
    check("b_final_count", 32'(move_count), 11);

    // Game C: 5/4, colour filter then a win on the last allowed move
    corner_color = 3'd2;
    new_game(5, 4, 5, 4, 11);
    gen_handshake(1'b0);
    reject_move(2, 0);
    reject_move(5, 0);
    reject_move(7, 0);
    for (int i = 1; i <= 11; i++) begin
      do_move(3, (i == 11), i, (i == 11) ? 1 : 0);
    end
    check("c_final_count", 32'(move_count), 11);

    // Game D: START ignored in GEN, flood_done+START and move+START aborts
    corner_color = 3'd0;
    new_game(14, 6, 14, 6, 27);
    gen_handshake(1'b1);
    move_valid = 1'b1;
    move_color = 3'd1;
    tick();
    move_valid = 1'b0;
    check("d_flood_pulse", 32'(flood_start), 1);
    flood_done = 1'b1;
    new_game(14, 6, 14, 6, 27);
    gen_handshake(1'b0);
    move_valid = 1'b1;
    move_color = 3'd2;
    new_game(0, 15, 2, 8, 11);

    // Reset mid-GEN
    check("pre_rst_init", 32'(INITIALIZE_BOARD), 1);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    check("mid_rst_init", 32'(INITIALIZE_BOARD), 0);
    check("mid_rst_seed", 32'(seed), 0);
    check("mid_rst_size", 32'(final_SIZE), 2);
    check("mid_rst_limit", 32'(move_limit), 0);
    check_status("mid_rst", 3);
    tick();
    check("post_rst_idle", 32'(INITIALIZE_BOARD), 0);
    check_status("post_rst", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
